// File: rtl/approx_mul_pkg.sv
// Shared constants and elaboration helpers for the approximate multiplier family.
package approx_mul_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Rounding bias 2^(l-1) added to a sum truncated below column l; zero when l = 0.
    function automatic logic [63:0] approx_bias(input int unsigned l);
        if (l == 0) begin
            return 64'd0;
        end
        return 64'd1 << (l - 1);
    endfunction

    // Legal parameter combinations for approx_umul_pipe.
    function automatic bit params_legal(input int unsigned w, input int unsigned l,
                                        input int unsigned er, input int unsigned st,
                                        input int unsigned tw);
        return (w >= 1) && (l <= 2 * w - 1) && (er <= w) && (st >= 1) && (tw >= 1);
    endfunction

endpackage

// File: rtl/approx_pp_sum.sv
// Combinational truncated-column partial-product summer.
// Low rows (x bits below W-EXACT_ROWS) drop columns below L in approximate mode;
// top EXACT_ROWS rows are always kept whole.
// Optional: APPROX_COMP_EN adds a 2^(L-1) rounding bias to approximate results.
module approx_pp_sum
    import approx_mul_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter int unsigned L          = 6,
    parameter int unsigned EXACT_ROWS = 2
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           mode,
    output logic [2*W-1:0] z
);

    localparam int unsigned PW       = 2 * W;
    localparam int unsigned LOW_ROWS = W - EXACT_ROWS;
    localparam logic [PW-1:0] KEEP_MASK = ~((PW'(1) << L) - PW'(1));
`ifdef APPROX_COMP_EN
    localparam logic [PW-1:0] BIAS = PW'(approx_bias(L));
`endif

    logic [PW-1:0] sum;

    // Row-by-row accumulation; low rows are masked in approximate mode.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (x[i]) begin
                if ((mode == MODE_APPROX) && (i < LOW_ROWS)) begin
                    sum = sum + ((PW'(y) << i) & KEEP_MASK);
                end else begin
                    sum = sum + (PW'(y) << i);
                end
            end
        end
    end

`ifdef APPROX_COMP_EN
    // Biased output for approximate mode, wrapping at 2W bits.
    assign z = (mode == MODE_APPROX) ? (sum + BIAS) : sum;
`else
    // Plain truncated sum.
    assign z = sum;
`endif

endmodule

// File: rtl/approx_umul_pipe.sv
// Pipelined W x W unsigned multiplier with per-op exact/approximate mode,
// valid/ready handshake, sideband tag and saturating accept counter.
// Optional: define APPROX_COMP_EN to bias approximate results (see approx_pp_sum).
module approx_umul_pipe
    import approx_mul_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter int unsigned L          = 6,
    parameter int unsigned EXACT_ROWS = 2,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_mode,
    output logic [31:0]      op_count
);

    localparam int unsigned PW = 2 * W;

    if (!params_legal(W, L, EXACT_ROWS, STAGES, TAG_W)) begin : g_param_check
        $error("approx_umul_pipe: illegal parameter combination");
    end

    logic             advance;
    logic             accept;
    logic             s1_valid;
    logic [W-1:0]     s1_x;
    logic [W-1:0]     s1_y;
    logic             s1_mode;
    logic [TAG_W-1:0] s1_tag;
    logic [PW-1:0]    s1_z;
    logic [31:0]      op_cnt_q;

    // Whole pipe moves together; it stalls only when the output is held.
    assign advance  = !out_valid || out_ready;
    assign accept   = in_valid && advance;
    assign in_ready = advance;
    assign op_count = op_cnt_q;

    // Stage 1: operand capture; a bubble enters when nothing is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_mode  <= 1'b0;
            s1_tag   <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_x    <= in_x;
                s1_y    <= in_y;
                s1_mode <= in_mode;
                s1_tag  <= in_tag;
            end
        end
    end

    approx_pp_sum #(
        .W          (W),
        .L          (L),
        .EXACT_ROWS (EXACT_ROWS)
    ) u_pp_sum (
        .x    (s1_x),
        .y    (s1_y),
        .mode (s1_mode),
        .z    (s1_z)
    );

    if (STAGES == 1) begin : g_single
        assign out_valid = s1_valid;
        assign out_z     = s1_z;
        assign out_tag   = s1_tag;
        assign out_mode  = s1_mode;
    end else begin : g_multi
        logic             p_valid [STAGES-1];
        logic [PW-1:0]    p_z     [STAGES-1];
        logic [TAG_W-1:0] p_tag   [STAGES-1];
        logic             p_mode  [STAGES-1];

        // Result slots 2..STAGES carrying the product toward the output.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned k = 0; k < STAGES - 1; k++) begin
                    p_valid[k] <= 1'b0;
                    p_z[k]     <= '0;
                    p_tag[k]   <= '0;
                    p_mode[k]  <= 1'b0;
                end
            end else if (advance) begin
                p_valid[0] <= s1_valid;
                p_z[0]     <= s1_z;
                p_tag[0]   <= s1_tag;
                p_mode[0]  <= s1_mode;
                for (int unsigned k = 1; k < STAGES - 1; k++) begin
                    p_valid[k] <= p_valid[k-1];
                    p_z[k]     <= p_z[k-1];
                    p_tag[k]   <= p_tag[k-1];
                    p_mode[k]  <= p_mode[k-1];
                end
            end
        end

        assign out_valid = p_valid[STAGES-2];
        assign out_z     = p_z[STAGES-2];
        assign out_tag   = p_tag[STAGES-2];
        assign out_mode  = p_mode[STAGES-2];
    end

    // Saturating count of accepted operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt_q <= '0;
        end else if (accept && (op_cnt_q != '1)) begin
            op_cnt_q <= op_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_approx_umul_pipe.sv
// Scoreboard bench for approx_umul_pipe: default W=8 instance plus a W=12 instance.
module tb_approx_umul_pipe;

    localparam int unsigned W   = 8,  L  = 6,  ER  = 2, ST  = 2, TW  = 4;
    localparam int unsigned W2  = 12, L2 = 10, ER2 = 3, ST2 = 3, TW2 = 5;
    localparam int unsigned N_RAND = 5000;
    localparam int unsigned BOUND  = 200;

    typedef struct packed {
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] z;
        logic        mode;
        logic [7:0]  tag;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance
    logic            in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [W-1:0]    in_x, in_y;
    logic [TW-1:0]   in_tag, out_tag;
    logic [2*W-1:0]  out_z;
    logic [31:0]     op_count;

    // Wide instance
    logic            v2, r2, m2, ov2, or2, om2;
    logic [W2-1:0]   x2, y2;
    logic [TW2-1:0]  t2, ot2;
    logic [2*W2-1:0] oz2;
    logic [31:0]     cnt2;

    approx_umul_pipe #(.W(W), .L(L), .EXACT_ROWS(ER), .STAGES(ST), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .out_tag(out_tag), .out_mode(out_mode), .op_count(op_count));

    approx_umul_pipe #(.W(W2), .L(L2), .EXACT_ROWS(ER2), .STAGES(ST2), .TAG_W(TW2)) dut12 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2),
        .in_x(x2), .in_y(y2), .in_mode(m2), .in_tag(t2),
        .out_valid(ov2), .out_ready(or2), .out_z(oz2),
        .out_tag(ot2), .out_mode(om2), .op_count(cnt2));

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    last_acc_cyc = 0;
    int    lat_cyc = 0;
    bit    lat_armed = 0;
    bit    rnd_rdy = 0;
    bit    rnd_rdy2 = 0;
    int    n_out = 0;
    item_t q[$];
    item_t q2[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bit-level reference: enumerate partial products and keep the allowed ones.
    function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y,
                                            input logic mode, input int unsigned w,
                                            input int unsigned l, input int unsigned er);
        logic [63:0] s;
        s = 64'd0;
        for (int unsigned i = 0; i < w; i++)
            for (int unsigned j = 0; j < w; j++)
                if (x[i] && y[j] && (!mode || (i >= w - er) || (i + j >= l)))
                    s = s + (64'd1 << (i + j));
`ifdef APPROX_COMP_EN
        if (mode && l >= 1) s = (s + (64'd1 << (l - 1))) & ((64'd1 << (2 * w)) - 64'd1);
`endif
        return s;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) if (rnd_rdy) begin #1; out_ready = ($urandom_range(0, 3) != 0); end
    always @(posedge clk) if (rnd_rdy2) begin #1; or2 = ($urandom_range(0, 2) != 0); end

    // Output scoreboard for the default instance.
    always @(negedge clk) begin
        item_t it;
        if (!rst) begin
            if (lat_armed && out_valid) begin
                lat_cyc = cyc;
                lat_armed = 0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    it = q.pop_front();
                    n_out++;
                    check("z", 64'(out_z), it.z);
                    check("tag", 64'(out_tag), it.tag);
                    check("mode", 64'(out_mode), 64'(it.mode));
`ifndef APPROX_COMP_EN
                    if (it.mode)
                        check("err_bound", 64'((64'(out_z) <= it.x * it.y) &&
                              (it.x * it.y - 64'(out_z) < 64'((W - ER) << L))), 64'd1);
`endif
                end
            end
        end
    end

    // Output scoreboard for the wide instance.
    always @(negedge clk) begin
        item_t it;
        if (!rst && ov2 && or2) begin
            if (q2.size() == 0) begin
                check("w12_spurious_out", 64'd1, 64'd0);
            end else begin
                it = q2.pop_front();
                check("w12_z", 64'(oz2), it.z);
                check("w12_tag", 64'(ot2), it.tag);
                if (!it.mode) check("w12_exact", 64'(oz2), it.x * it.y);
`ifndef APPROX_COMP_EN
                else check("w12_err_bound", 64'((64'(oz2) <= it.x * it.y) &&
                           (it.x * it.y - 64'(oz2) < 64'((W2 - ER2) << L2))), 64'd1);
`endif
            end
        end
    end

    task automatic send(input logic [63:0] x, input logic [63:0] y, input logic mode,
                        input logic [7:0] tag, input logic [63:0] exp);
        int n;
        in_x = W'(x); in_y = W'(y); in_mode = mode; in_tag = TW'(tag); in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < BOUND) begin @(negedge clk); n++; end
        if (!in_ready) check("send_timeout", 64'd0, 64'd1);
        else begin
            q.push_back('{x: x, y: y, z: exp, mode: mode, tag: tag});
            last_acc_cyc = cyc;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic [63:0] x, input logic [63:0] y, input logic mode,
                         input logic [7:0] tag);
        int n;
        x2 = W2'(x); y2 = W2'(y); m2 = mode; t2 = TW2'(tag); v2 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!r2 && n < BOUND) begin @(negedge clk); n++; end
        if (!r2) check("w12_send_timeout", 64'd0, 64'd1);
        else q2.push_back('{x: x, y: y, z: ref_mul(x, y, mode, W2, L2, ER2), mode: mode, tag: tag});
        @(posedge clk); #1;
        v2 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || q2.size() != 0) && n < 4 * BOUND) begin @(negedge clk); n++; end
        check("drain_q", 64'(q.size()), 64'd0);
        check("drain_q2", 64'(q2.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rand_op(input int unsigned w);
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return (64'd1 << w) - 64'd1;
            default: return 64'($urandom) & ((64'd1 << w) - 64'd1);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, n0;
        logic [63:0] a, b;
        logic md;
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_mode = 1'b0; in_tag = '0;
        out_ready = 1'b1;
        v2 = 1'b0; x2 = '0; y2 = '0; m2 = 1'b0; t2 = '0; or2 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_z", 64'(out_z), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_mode", 64'(out_mode), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Streaming with latency and count
        lat_armed = 1;
        for (int t = 0; t < 10; t++) begin
            send(64'(t * 7 + 3), 64'(t * 13 + 5), 1'(t % 2), 8'(t),
                 ref_mul(64'(t * 7 + 3), 64'(t * 13 + 5), 1'(t % 2), W, L, ER));
            if (t == 0) acc0 = last_acc_cyc;
        end
        drain();
        check("latency", 64'(lat_cyc - acc0), 64'(ST));
        check("stream_op_count", 64'(op_count), 64'd10);
        check("stream_outputs", 64'(n_out), 64'd10);

        // Directed values
`ifdef APPROX_COMP_EN
        send(255, 255, 1, 1, 64736);
        send(3, 3, 1, 3, 32);
        send(0, 0, 1, 5, 32);
`else
        send(255, 255, 1, 1, 64704);
        send(3, 3, 1, 3, 0);
        send(0, 0, 1, 5, 0);
`endif
        send(255, 255, 0, 0, 65025);
        send(3, 3, 0, 2, 9);
        send(64, 5, 0, 4, 320);
        send(64, 5, 1, 6, 320);
        send(0, 0, 0, 7, 0);
        send(0, 173, 0, 8, 0);
        drain();

        // Backpressure: fill, hold 5 cycles, release
        n0 = n_out;
        out_ready = 1'b0;
        send(10, 11, 0, 5, 110);
        send(12, 13, 1, 6, ref_mul(12, 13, 1, W, L, ER));
        in_x = 8'd20; in_y = 8'd21; in_mode = 1'b0; in_tag = 4'd7; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_z", 64'(out_z), 64'd110);
            check("stall_out_tag", 64'(out_tag), 64'd5);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(20, 21, 0, 7, 420);
        drain();
        check("stall_outputs", 64'(n_out - n0), 64'd3);

        // Reset with two ops in flight
        out_ready = 1'b0;
        send(200, 100, 0, 9, 20000);
        send(150, 150, 0, 10, 22500);
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_op_count", 64'(op_count), 64'd0);
        check("flush_out_z", 64'(out_z), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Random sweep on both instances
        n0 = n_out;
        rnd_rdy = 1; rnd_rdy2 = 1;
        fork
            begin
                for (int n = 0; n < int'(N_RAND); n++) begin
                    if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
                    a = rand_op(W); b = rand_op(W); md = 1'($urandom_range(0, 1));
                    send(a, b, md, 8'($urandom_range(0, 15)), ref_mul(a, b, md, W, L, ER));
                end
            end
            begin
                for (int n = 0; n < int'(N_RAND); n++) begin
                    logic [63:0] c, d;
                    logic e;
                    if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
                    c = rand_op(W2); d = rand_op(W2); e = 1'($urandom_range(0, 1));
                    send2(c, d, e, 8'($urandom_range(0, 31)));
                end
            end
        join
        @(posedge clk);
        rnd_rdy = 0; rnd_rdy2 = 0;
        #1;
        out_ready = 1'b1; or2 = 1'b1;
        drain();
        check("rand_outputs", 64'(n_out - n0), 64'(N_RAND));
        check("rand_op_count", 64'(op_count), 64'(N_RAND));
        check("w12_op_count", 64'(cnt2), 64'(N_RAND));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
